// File: rtl/pushbox_pkg.sv
// pushbox_pkg: key codes, direction/FSM encodings and decode helpers for the PushBox command path.
package pushbox_pkg;
    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_BACK  = 8'h08;
    localparam logic [7:0] KEY_ESC   = 8'h1B;
    localparam logic [7:0] KEY_UP    = 8'h1E;
    localparam logic [7:0] KEY_DOWN  = 8'h1F;
    localparam logic [7:0] KEY_LEFT  = 8'h1D;
    localparam logic [7:0] KEY_RIGHT = 8'h1C;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {BOOT, IDLE, WAIT} state_e;

    typedef struct packed {
        logic       pushed;
        logic [1:0] dir;
    } hist_t;

    typedef struct packed {
        logic       inp;
        logic       idx;
        logic       clr;
        logic       mov;
        logic       und;
        logic       restart;
        logic       ext;
        logic       pull;
        logic [1:0] dir;
        logic [7:0] ascii;
    } cmd_t;

    function automatic logic is_arrow(input logic [7:0] k);
        return k == KEY_UP || k == KEY_DOWN || k == KEY_LEFT || k == KEY_RIGHT;
    endfunction

    function automatic logic [1:0] key_dir(input logic [7:0] k);
        return k == KEY_UP ? DIR_UP : k == KEY_DOWN ? DIR_DOWN : k == KEY_LEFT ? DIR_LEFT : DIR_RIGHT;
    endfunction

    // Up/down and left/right differ only in bit 0.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction
endpackage

// File: rtl/pushbox_cmd_ctrl_if.sv
// pushbox_cmd_ctrl_if: key input, engine handshake and command outputs of the PushBox dispatcher.
interface pushbox_cmd_ctrl_if #(parameter int STEP_W = 16);
    logic [7:0]        ascii;
    logic              ready;
    logic              key_break;
    logic              cmd_done;
    logic              move_ok;
    logic              move_pushed;
    logic              load_done;
    logic              mode;
    logic              input_pulse;
    logic              clear_pulse;
    logic              index_pulse;
    logic              move_pulse;
    logic              undo_pulse;
    logic              undo_pull;
    logic [1:0]        direction;
    logic              restart_pulse;
    logic              exit_pulse;
    logic [7:0]        cmd_ascii;
    logic [STEP_W-1:0] step;
    logic              undo_avail;
    logic              key_drop;

    modport master (
        output ascii, ready, key_break, cmd_done, move_ok, move_pushed, load_done,
        input  mode, input_pulse, clear_pulse, index_pulse, move_pulse, undo_pulse, undo_pull,
               direction, restart_pulse, exit_pulse, cmd_ascii, step, undo_avail, key_drop
    );

    modport slave (
        input  ascii, ready, key_break, cmd_done, move_ok, move_pushed, load_done,
        output mode, input_pulse, clear_pulse, index_pulse, move_pulse, undo_pulse, undo_pull,
               direction, restart_pulse, exit_pulse, cmd_ascii, step, undo_avail, key_drop
    );
endinterface

// File: rtl/pushbox_key_fifo.sv
// pushbox_key_fifo: synchronous FIFO with head-of-queue read; a push while full is discarded even if a pop coincides.
module pushbox_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rp_q];

    always_ff @(posedge clk)
        if (do_push) mem_q[wp_q] <= data_i;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(do_push);
            rp_q  <= rp_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/pushbox_cmd_ctrl.sv
// pushbox_cmd_ctrl: PushBox key dispatcher with one command in flight, undo history and step counter.
module pushbox_cmd_ctrl
    import pushbox_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int UNDO_DEPTH  = 16,
    parameter int STEP_W      = 16,
    parameter int BOOT_DELAY  = 500000
) (
    input logic               clk,
    input logic               rst,
    pushbox_cmd_ctrl_if.slave bus
);
    localparam int CW  = $clog2(BOOT_DELAY + 1);
    localparam int HW  = $clog2(UNDO_DEPTH);
    localparam int HCW = HW + 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mode_q, mode_d;
    cmd_t              cmd_q, cmd_d;
    logic              wmove_q, wmove_d, wundo_q, wundo_d;
    logic [1:0]        wdir_q, wdir_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [HW-1:0]     hp_q, hp_d;
    logic [HCW-1:0]    hc_q, hc_d;
    logic              drop_q;
    hist_t             hist_q [UNDO_DEPTH];
    hist_t             hist_top;
    logic              hist_we, pop, go, push, empty, full;
    logic [7:0]        head;

    assign push     = bus.ready && !bus.key_break;
    assign hist_top = hist_q[hp_q - HW'(1)];

    pushbox_key_fifo #(.DEPTH(QUEUE_DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .data_i (bus.ascii),
        .data_o (head),
        .empty_o(empty),
        .full_o (full)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        cmd_d   = '0;
        wmove_d = wmove_q;
        wundo_d = wundo_q;
        wdir_d  = wdir_q;
        step_d  = step_q;
        hp_d    = hp_q;
        hc_d    = hc_q;
        pop     = 1'b0;
        go      = 1'b0;
        hist_we = 1'b0;
        if (state_q == BOOT) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = cnt_q == CW'(BOOT_DELAY - 1) ? IDLE : BOOT;
        end else if (state_q == IDLE) begin
            pop = !empty;
            if (!empty && !mode_q) begin
                cmd_d.inp = head >= 8'h20 || head == KEY_BACK;
                cmd_d.idx = head == KEY_ENTER;
                cmd_d.clr = head == KEY_ESC;
            end else if (!empty) begin
                cmd_d.mov     = is_arrow(head);
                cmd_d.und     = head == KEY_BACK && hc_q != '0;
                cmd_d.restart = head == KEY_ENTER;
                cmd_d.ext     = head == KEY_ESC;
                cmd_d.pull    = cmd_d.und && hist_top.pushed;
                cmd_d.dir     = cmd_d.mov ? key_dir(head) : cmd_d.und ? opposite(hist_top.dir) : DIR_UP;
            end
            go          = cmd_d.inp || cmd_d.idx || cmd_d.clr || cmd_d.mov || cmd_d.und || cmd_d.restart;
            cmd_d.ascii = (go || cmd_d.ext) ? head : 8'h00;
            if (cmd_d.ext) mode_d = 1'b0;
            if (cmd_d.und) begin
                hp_d = hp_q - HW'(1);
                hc_d = hc_q - HCW'(1);
            end
            if (go) begin
                state_d = WAIT;
                wmove_d = cmd_d.mov;
                wundo_d = cmd_d.und;
                wdir_d  = cmd_d.dir;
            end
        end else if (bus.cmd_done) begin
            state_d = IDLE;
            hist_we = wmove_q && bus.move_ok;
            if (hist_we) begin
                hp_d   = hp_q + HW'(1);
                hc_d   = hc_q == HCW'(UNDO_DEPTH) ? hc_q : hc_q + HCW'(1);
                step_d = &step_q ? step_q : step_q + STEP_W'(1);
            end
            if (wundo_q) step_d = step_q == '0 ? step_q : step_q - STEP_W'(1);
        end
        // A finished level load overrides any completion arriving in the same cycle.
        if (bus.load_done) begin
            mode_d  = 1'b1;
            hc_d    = '0;
            step_d  = '0;
            hist_we = 1'b0;
            if (state_q == WAIT) state_d = IDLE;
        end
    end

    always_ff @(posedge clk)
        if (hist_we) hist_q[hp_q] <= {bus.move_pushed, wdir_q};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            wmove_q <= 1'b0;
            wundo_q <= 1'b0;
            wdir_q  <= '0;
            step_q  <= '0;
            hp_q    <= '0;
            hc_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            wmove_q <= wmove_d;
            wundo_q <= wundo_d;
            wdir_q  <= wdir_d;
            step_q  <= step_d;
            hp_q    <= hp_d;
            hc_q    <= hc_d;
            drop_q  <= push && full;
        end

    assign bus.mode          = mode_q;
    assign bus.input_pulse   = cmd_q.inp;
    assign bus.index_pulse   = cmd_q.idx;
    assign bus.clear_pulse   = cmd_q.clr;
    assign bus.move_pulse    = cmd_q.mov;
    assign bus.undo_pulse    = cmd_q.und;
    assign bus.undo_pull     = cmd_q.pull;
    assign bus.direction     = cmd_q.dir;
    assign bus.restart_pulse = cmd_q.restart;
    assign bus.exit_pulse    = cmd_q.ext;
    assign bus.cmd_ascii     = cmd_q.ascii;
    assign bus.step          = step_q;
    assign bus.undo_avail    = hc_q != '0;
    assign bus.key_drop      = drop_q;
endmodule

// File: tb/tb_pushbox_cmd_ctrl.sv
// tb_pushbox_cmd_ctrl: table-driven decode vectors plus hand sequences for boot, queue overflow, reset and load races.
module tb_pushbox_cmd_ctrl;
    localparam logic [6:0] P_IN  = 7'b1000000;
    localparam logic [6:0] P_IDX = 7'b0100000;
    localparam logic [6:0] P_CLR = 7'b0010000;
    localparam logic [6:0] P_MV  = 7'b0001000;
    localparam logic [6:0] P_UN  = 7'b0000100;
    localparam logic [6:0] P_RS  = 7'b0000010;
    localparam logic [6:0] P_EX  = 7'b0000001;

    typedef struct {
        logic        load;
        logic [7:0]  key;
        logic [6:0]  pv;
        logic [1:0]  dir;
        logic        pull;
        logic        ok;
        logic        pushed;
        logic [15:0] stp;
        logic        avail;
        logic        md;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[$];

    pushbox_cmd_ctrl_if #(.STEP_W(16)) bus();

    pushbox_cmd_ctrl #(.QUEUE_DEPTH(4), .UNDO_DEPTH(4), .STEP_W(16), .BOOT_DELAY(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [7:0] k, input logic [6:0] p, input logic [1:0] d,
                                input logic pl, input logic ok, input logic ps, input logic [15:0] s,
                                input logic a, input logic m);
        vec_t v;
        v.load = ld; v.key = k; v.pv = p; v.dir = d; v.pull = pl;
        v.ok = ok; v.pushed = ps; v.stp = s; v.avail = a; v.md = m;
        return v;
    endfunction

    function automatic logic [6:0] pulses();
        return {bus.input_pulse, bus.index_pulse, bus.clear_pulse, bus.move_pulse,
                bus.undo_pulse, bus.restart_pulse, bus.exit_pulse};
    endfunction

    function automatic logic outs_any();
        return |{bus.mode, pulses(), bus.undo_pull, bus.direction, bus.cmd_ascii,
                 bus.step, bus.undo_avail, bus.key_drop};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] k);
        bus.ascii = k;
        bus.ready = 1'b1;
        step_clk();
        bus.ready = 1'b0;
        bus.ascii = 8'h00;
    endtask

    task automatic done(input logic ok, input logic ps);
        bus.cmd_done = 1'b1;
        bus.move_ok = ok;
        bus.move_pushed = ps;
        step_clk();
        bus.cmd_done = 1'b0;
        bus.move_ok = 1'b0;
        bus.move_pushed = 1'b0;
    endtask

    task automatic load();
        bus.load_done = 1'b1;
        step_clk();
        bus.load_done = 1'b0;
    endtask

    // Watch n cycles; report how many had a pulse and the outputs of the first one.
    task automatic collect(input int n, output logic [6:0] pv, output logic [1:0] d, output logic pl,
                           output logic [7:0] ca, output int hits, output int first);
        pv = '0; d = '0; pl = 1'b0; ca = '0; hits = 0; first = 0;
        for (int c = 1; c <= n; c++) begin
            step_clk();
            if (pulses() != '0) begin
                hits++;
                if (first == 0) begin
                    first = c; pv = pulses(); d = bus.direction; pl = bus.undo_pull; ca = bus.cmd_ascii;
                end
            end
        end
    endtask

    task automatic run_row(input int i, input vec_t v);
        logic [6:0] pv;
        logic [1:0] d;
        logic       pl;
        logic [7:0] ca;
        int         hits, first;
        if (v.load) load();
        send_key(v.key);
        collect(4, pv, d, pl, ca, hits, first);
        if (v.pv == '0) chk($sformatf("row%0d no_pulse", i), hits, 0);
        else begin
            chk($sformatf("row%0d hits", i), hits, 1);
            chk($sformatf("row%0d latency", i), first, 1);
            chk($sformatf("row%0d pulse", i), pv, v.pv);
            chk($sformatf("row%0d cmd_ascii", i), ca, v.key);
            if ((v.pv & (P_MV | P_UN)) != '0) begin
                chk($sformatf("row%0d dir", i), d, v.dir);
                chk($sformatf("row%0d pull", i), pl, v.pull);
            end
            if (v.pv != P_EX) done(v.ok, v.pushed);
        end
        step_clk();
        chk($sformatf("row%0d step", i), bus.step, v.stp);
        chk($sformatf("row%0d undo_avail", i), bus.undo_avail, v.avail);
        chk($sformatf("row%0d mode", i), bus.mode, v.md);
    endtask

    initial begin
        logic [6:0] pv;
        logic [1:0] d;
        logic       pl;
        logic [7:0] ca;
        int         h1, h2, first;
        bus.ascii = '0; bus.ready = 0; bus.key_break = 0; bus.cmd_done = 0;
        bus.move_ok = 0; bus.move_pushed = 0; bus.load_done = 0;
        // ld key pulse dir pull ok pushed step avail mode
        tv.push_back(mk(1'b0, 8'h08, P_IN,  2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 8'h0D, P_IDX, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 8'h1B, P_CLR, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 8'h05, 7'd0,  2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 8'h1F, 7'd0,  2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b0, 8'h7E, P_IN,  2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
        tv.push_back(mk(1'b1, 8'h1E, P_MV,  2'd0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, P_UN,  2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, 7'd0,  2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
        tv.push_back(mk(1'b0, 8'h1D, P_MV,  2'd2, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
        tv.push_back(mk(1'b0, 8'h1C, P_MV,  2'd3, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, P_UN,  2'd2, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
        tv.push_back(mk(1'b0, 8'h1F, P_MV,  2'd1, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h0D, P_RS,  2'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h61, 7'd0,  2'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h1B, P_EX,  2'd0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0));
        tv.push_back(mk(1'b1, 8'h1E, P_MV,  2'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h1D, P_MV,  2'd2, 1'b0, 1'b1, 1'b0, 16'd2, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h1C, P_MV,  2'd3, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h1F, P_MV,  2'd1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h1E, P_MV,  2'd0, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h1D, P_MV,  2'd2, 1'b0, 1'b1, 1'b0, 16'd6, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, P_UN,  2'd3, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, P_UN,  2'd1, 1'b1, 1'b0, 1'b0, 16'd4, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, P_UN,  2'd0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, P_UN,  2'd2, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1));
        tv.push_back(mk(1'b0, 8'h08, 7'd0,  2'd0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1));

        // Boot: key arrives mid-boot and is dispatched only once the delay has elapsed.
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", outs_any(), 0);
        rst = 1'b0;
        collect(2, pv, d, pl, ca, h1, first);
        send_key(8'h61);
        collect(5, pv, d, pl, ca, h2, first);
        chk("boot no early pulse", h1 + h2, 0);
        collect(4, pv, d, pl, ca, h1, first);
        chk("boot hits", h1, 1);
        chk("boot latency", first, 1);
        chk("boot pulse", pv, P_IN);
        chk("boot cmd_ascii", ca, 8'h61);
        done(1'b0, 1'b0);

        bus.key_break = 1'b1;
        send_key(8'h41);
        bus.key_break = 1'b0;
        collect(4, pv, d, pl, ca, h1, first);
        chk("break ignored", h1, 0);

        // Queue overflow while the first command waits for completion.
        send_key(8'h62);
        collect(4, pv, d, pl, ca, h1, first);
        chk("q first ascii", ca, 8'h62);
        for (int i = 0; i < 5; i++) begin
            bus.ascii = 8'h31 + 8'(i);
            bus.ready = 1'b1;
            step_clk();
            chk($sformatf("q key_drop %0d", i), bus.key_drop, i == 4);
        end
        bus.ready = 1'b0;
        step_clk();
        chk("q key_drop clear", bus.key_drop, 0);
        done(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            collect(4, pv, d, pl, ca, h1, first);
            chk($sformatf("q%0d hits", i), h1, 1);
            chk($sformatf("q%0d pulse", i), pv, P_IN);
            chk($sformatf("q%0d ascii", i), ca, 8'h31 + 8'(i));
            done(1'b0, 1'b0);
        end
        collect(4, pv, d, pl, ca, h1, first);
        chk("q fifth dropped", h1, 0);

        for (int i = 0; i < tv.size(); i++) run_row(i, tv[i]);

        // Reset during WAIT with a key still queued.
        send_key(8'h1E);
        collect(4, pv, d, pl, ca, h1, first);
        chk("rst move issued", pv, P_MV);
        send_key(8'h61);
        rst = 1'b1;
        #1;
        chk("rst outputs", outs_any(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        collect(14, pv, d, pl, ca, h1, first);
        chk("rst queue empty", h1, 0);
        chk("rst outputs after boot", outs_any(), 0);

        // load_done coinciding with cmd_done discards the move.
        load();
        send_key(8'h1E);
        collect(4, pv, d, pl, ca, h1, first);
        done(1'b1, 1'b1);
        step_clk();
        chk("ld step before", bus.step, 1);
        send_key(8'h1D);
        collect(4, pv, d, pl, ca, h1, first);
        chk("ld move issued", pv, P_MV);
        bus.load_done = 1'b1;
        bus.cmd_done = 1'b1;
        bus.move_ok = 1'b1;
        step_clk();
        bus.load_done = 1'b0;
        bus.cmd_done = 1'b0;
        bus.move_ok = 1'b0;
        step_clk();
        chk("ld step", bus.step, 0);
        chk("ld undo_avail", bus.undo_avail, 0);
        chk("ld mode", bus.mode, 1);
        send_key(8'h1C);
        collect(4, pv, d, pl, ca, h1, first);
        chk("ld idle pulse", pv, P_MV);
        chk("ld idle dir", d, 2'd3);
        done(1'b1, 1'b0);
        step_clk();
        chk("ld step after", bus.step, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
